// File: rtl/board_input_decoder.sv
// Board input front end: synchronizes switches, debounces five push buttons and
// decodes the rotary encoder into detent pulses and a position (macro ROTARY_DECODE_EN).
module board_input_decoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CCLK,
    input  logic       rst,
    input  logic [3:0] SW,
    input  logic       BTNN,
    input  logic       BTNE,
    input  logic       BTNS,
    input  logic       BTNW,
    input  logic       ROTCTR,
    input  logic       ROTA,
    input  logic       ROTB,
    output logic [3:0] sw_sync,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic       rot_right,
    output logic       rot_left,
    output logic [7:0] rot_pos
);

    localparam int         NBTN     = 5;
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0] btn_raw;
    logic [3:0]      sw_p0;
    logic [NBTN-1:0] btn_p0;
    logic [NBTN-1:0] btn_p1;
    logic [15:0]     cnt [NBTN];

    assign btn_raw = {ROTCTR, BTNW, BTNS, BTNE, BTNN};

    // Stage p0/p1: two-flop synchronizers; sw_sync is the second switch flop.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            sw_p0   <= '0;
            sw_sync <= '0;
            btn_p0  <= '0;
            btn_p1  <= '0;
        end else begin
            sw_p0   <= SW;
            sw_sync <= sw_p0;
            btn_p0  <= btn_raw;
            btn_p1  <= btn_p0;
        end
    end

    // Debounce stage: the level flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;
                if (btn_p1[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]         <= '0;
                    btn_level[i]   <= btn_p1[i];
                    btn_press[i]   <= btn_p1[i];
                    btn_release[i] <= ~btn_p1[i];
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

`ifdef ROTARY_DECODE_EN
    logic [1:0] rot_p0;
    logic [1:0] rot_p1;
    logic       q1;
    logic       q2;
    logic       q1_prev;
    logic       step_r;
    logic       step_l;

    // A detent is a fresh rise of q1; q2 remembers which mixed state led into it.
    assign step_r = q1 & ~q1_prev & ~q2;
    assign step_l = q1 & ~q1_prev &  q2;

    // Stage p0/p1: synchronize the quadrature pair as {A,B}.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            rot_p0 <= '0;
            rot_p1 <= '0;
        end else begin
            rot_p0 <= {ROTA, ROTB};
            rot_p1 <= rot_p0;
        end
    end

    // Decode stage: q1/q2 state, rise detection, pulse and position update.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            q1        <= 1'b0;
            q2        <= 1'b0;
            q1_prev   <= 1'b0;
            rot_right <= 1'b0;
            rot_left  <= 1'b0;
            rot_pos   <= '0;
        end else begin
            if (rot_p1 == 2'b11) begin
                q1 <= 1'b1;
            end else if (rot_p1 == 2'b00) begin
                q1 <= 1'b0;
            end
            if (rot_p1 == 2'b01) begin
                q2 <= 1'b1;
            end else if (rot_p1 == 2'b10) begin
                q2 <= 1'b0;
            end
            q1_prev   <= q1;
            rot_right <= step_r;
            rot_left  <= step_l;
            if (step_r) begin
                rot_pos <= rot_pos + 8'd1;
            end else if (step_l) begin
                rot_pos <= rot_pos - 8'd1;
            end
        end
    end
`else
    logic unused_rot;

    assign unused_rot = ROTA ^ ROTB;
    assign rot_right  = 1'b0;
    assign rot_left   = 1'b0;
    assign rot_pos    = 8'h00;
`endif

endmodule

// File: tb/tb_board_input_decoder.sv
// Self-checking bench for board_input_decoder with DEBOUNCE_CYCLES=4; rotary checks
// follow whether ROTARY_DECODE_EN is defined for the build.
module tb_board_input_decoder;

    localparam int DEB = 4;

    logic       CCLK = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] SW = '0;
    logic       BTNN = 1'b0, BTNE = 1'b0, BTNS = 1'b0, BTNW = 1'b0, ROTCTR = 1'b0;
    logic       ROTA = 1'b0, ROTB = 1'b0;
    logic [3:0] sw_sync;
    logic [4:0] btn_level, btn_press, btn_release;
    logic       rot_right, rot_left;
    logic [7:0] rot_pos;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_r    = 0;
    int cnt_l    = 0;

    board_input_decoder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .CCLK(CCLK), .rst(rst), .SW(SW),
        .BTNN(BTNN), .BTNE(BTNE), .BTNS(BTNS), .BTNW(BTNW), .ROTCTR(ROTCTR),
        .ROTA(ROTA), .ROTB(ROTB),
        .sw_sync(sw_sync), .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .rot_right(rot_right), .rot_left(rot_left),
        .rot_pos(rot_pos)
    );

    always #5 CCLK = ~CCLK;

    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    task automatic zero_inputs();
        SW = '0;
        {ROTCTR, BTNW, BTNS, BTNE, BTNN} = '0;
        ROTA = 1'b0;
        ROTB = 1'b0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic rot_hold(input logic [1:0] ab, input int n);
        ROTA = ab[1];
        ROTB = ab[0];
        repeat (n) begin
            tick();
            if (rot_right) cnt_r++;
            if (rot_left) cnt_l++;
        end
    endtask

    task automatic detent_right();
        rot_hold(2'b00, 3); rot_hold(2'b10, 3); rot_hold(2'b11, 3);
        rot_hold(2'b01, 3); rot_hold(2'b00, 3);
    endtask

    task automatic detent_left();
        rot_hold(2'b00, 3); rot_hold(2'b01, 3); rot_hold(2'b11, 3);
        rot_hold(2'b10, 3); rot_hold(2'b00, 3);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            SW = 4'($urandom);
            {ROTCTR, BTNW, BTNS, BTNE, BTNN} = 5'($urandom);
            {ROTA, ROTB} = 2'($urandom);
            tick();
        end
        zero_inputs();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({sw_sync, btn_level, btn_press, btn_release, rot_right, rot_left, rot_pos} !== 29'd0)
            $display("FAIL reset_outputs: got %h required 0",
                     {sw_sync, btn_level, btn_press, btn_release, rot_right, rot_left, rot_pos});
        else n_pass++;
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_sw();
        logic [3:0] v;
        SW = 4'b1010;
        tick();
        n_checks++;
        if (sw_sync !== 4'b0000) $display("FAIL sw_edge1: got %b required 0000", sw_sync);
        else n_pass++;
        tick();
        n_checks++;
        if (sw_sync !== 4'b1010) $display("FAIL sw_edge2: got %b required 1010", sw_sync);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            v = 4'($urandom);
            SW = v;
            repeat (2) tick();
            n_checks++;
            if (sw_sync !== v) $display("FAIL sw_rand: got %b required %b", sw_sync, v);
            else n_pass++;
        end
        SW = '0;
        repeat (2) tick();
    endtask

    task automatic test_press_release();
        logic [4:0] el, ep, er;
        BTNW = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            el = (e >= 6) ? 5'b01000 : 5'b00000;
            ep = (e == 6) ? 5'b01000 : 5'b00000;
            n_checks++;
            if ({btn_level, btn_press, btn_release} !== {el, ep, 5'b0})
                $display("FAIL press_edge%0d: got lvl=%b prs=%b rls=%b required lvl=%b prs=%b rls=00000",
                         e, btn_level, btn_press, btn_release, el, ep);
            else n_pass++;
        end
        BTNW = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            el = (e >= 6) ? 5'b00000 : 5'b01000;
            er = (e == 6) ? 5'b01000 : 5'b00000;
            n_checks++;
            if ({btn_level, btn_press, btn_release} !== {el, 5'b0, er})
                $display("FAIL release_edge%0d: got lvl=%b prs=%b rls=%b required lvl=%b prs=00000 rls=%b",
                         e, btn_level, btn_press, btn_release, el, er);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        BTNN = 1'b1;
        repeat (3) begin
            tick();
            if ({btn_level, btn_press, btn_release} !== 15'd0) bad++;
        end
        BTNN = 1'b0;
        repeat (8) begin
            tick();
            if ({btn_level, btn_press, btn_release} !== 15'd0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL glitch: got %0d nonzero cycles required 0", bad);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        BTNN = 1'b1;
        BTNS = 1'b1;
        repeat (6) tick();
        n_checks++;
        if ({btn_level, btn_press} !== {5'b00101, 5'b00101})
            $display("FAIL simultaneous_press: got lvl=%b prs=%b required 00101/00101", btn_level, btn_press);
        else n_pass++;
        tick();
        n_checks++;
        if (btn_press !== 5'b00000) $display("FAIL simultaneous_one_cycle: got %b required 00000", btn_press);
        else n_pass++;
        BTNN = 1'b0;
        BTNS = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (btn_release !== 5'b00101) $display("FAIL simultaneous_release: got %b required 00101", btn_release);
        else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        logic [4:0] ep;
`ifdef ROTARY_DECODE_EN
        do_reset();
        for (int i = 0; i < 7; i++) detent_right();
        n_checks++;
        if (rot_pos !== 8'd7) $display("FAIL pre_reset_pos: got %0d required 7", rot_pos);
        else n_pass++;
`endif
        BTNE = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({sw_sync, btn_level, btn_press, btn_release, rot_right, rot_left, rot_pos} !== 29'd0)
            $display("FAIL reset_mid_outputs: got %h required 0",
                     {sw_sync, btn_level, btn_press, btn_release, rot_right, rot_left, rot_pos});
        else n_pass++;
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            ep = (e == 6) ? 5'b00010 : 5'b00000;
            n_checks++;
            if (btn_press !== ep) $display("FAIL reset_rearm_edge%0d: got %b required %b", e, btn_press, ep);
            else n_pass++;
        end
        BTNE = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_random_buttons();
        logic [4:0] hist[$];
        logic [4:0] lvl, prs, rls, raw, syn;
        int run[5];
        int hold[5];
        do_reset();
        lvl = '0;
        raw = '0;
        hist.push_back(5'd0);
        hist.push_back(5'd0);
        for (int b = 0; b < 5; b++) begin
            run[b] = 0;
            hold[b] = $urandom_range(1, 10);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int b = 0; b < 5; b++) begin
                hold[b]--;
                if (hold[b] == 0) begin
                    raw[b] = ~raw[b];
                    hold[b] = $urandom_range(1, 10);
                end
            end
            {ROTCTR, BTNW, BTNS, BTNE, BTNN} = raw;
            hist.push_back(raw);
            // level seen by the debouncer is the raw value from two edges back
            syn = hist[hist.size() - 3];
            prs = '0;
            rls = '0;
            for (int b = 0; b < 5; b++) begin
                if (syn[b] != lvl[b]) begin
                    run[b]++;
                    if (run[b] == DEB) begin
                        run[b] = 0;
                        lvl[b] = syn[b];
                        if (syn[b]) prs[b] = 1'b1;
                        else rls[b] = 1'b1;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            tick();
            n_checks++;
            if ({btn_level, btn_press, btn_release} !== {lvl, prs, rls})
                $display("FAIL rand_btn_cyc%0d: got lvl=%b prs=%b rls=%b required lvl=%b prs=%b rls=%b",
                         cyc, btn_level, btn_press, btn_release, lvl, prs, rls);
            else n_pass++;
        end
        zero_inputs();
        repeat (10) tick();
    endtask

`ifdef ROTARY_DECODE_EN
    task automatic test_rot_direction();
        do_reset();
        cnt_r = 0; cnt_l = 0;
        detent_right();
        rot_hold(2'b00, 3);
        n_checks++;
        if ({cnt_r, cnt_l} !== {32'd1, 32'd0} || rot_pos !== 8'd1)
            $display("FAIL rot_right_seq: got r=%0d l=%0d pos=%0d required r=1 l=0 pos=1", cnt_r, cnt_l, rot_pos);
        else n_pass++;
        cnt_r = 0; cnt_l = 0;
        detent_left();
        rot_hold(2'b00, 3);
        n_checks++;
        if ({cnt_r, cnt_l} !== {32'd0, 32'd1} || rot_pos !== 8'd0)
            $display("FAIL rot_left_seq: got r=%0d l=%0d pos=%0d required r=0 l=1 pos=0", cnt_r, cnt_l, rot_pos);
        else n_pass++;
        ROTA = 1'b1;
        ROTB = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_checks++;
            if ({rot_right, rot_left} !== ((e == 4) ? 2'b10 : 2'b00))
                $display("FAIL rot_latency_edge%0d: got r=%b l=%b required r=%b l=0",
                         e, rot_right, rot_left, (e == 4));
            else n_pass++;
        end
        rot_hold(2'b00, 4);
        cnt_r = 0; cnt_l = 0;
        for (int i = 0; i < 6; i++) rot_hold((i % 2) ? 2'b01 : 2'b10, 1 + (i % 3));
        rot_hold(2'b00, 4);
        n_checks++;
        if (cnt_r + cnt_l != 0) $display("FAIL rot_mixed_chatter: got %0d pulses required 0", cnt_r + cnt_l);
        else n_pass++;
    endtask

    task automatic test_rot_wrap();
        do_reset();
        detent_left();
        n_checks++;
        if (rot_pos !== 8'd255) $display("FAIL rot_wrap_down: got %0d required 255", rot_pos);
        else n_pass++;
        detent_right();
        detent_right();
        n_checks++;
        if (rot_pos !== 8'd1) $display("FAIL rot_wrap_up: got %0d required 1", rot_pos);
        else n_pass++;
    endtask

    task automatic test_rot_random();
        logic [1:0] gray[4];
        logic [1:0] ab;
        logic m_q1, m_q2;
        logic [7:0] m_pos;
        int idx, m_r, m_l, both;
        gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
        do_reset();
        cnt_r = 0; cnt_l = 0; both = 0;
        m_q1 = 1'b0; m_q2 = 1'b0; m_pos = 8'd0; m_r = 0; m_l = 0;
        idx = 0;
        for (int s = 0; s < 150; s++) begin
            idx = ($urandom_range(0, 1) == 1) ? (idx + 1) % 4 : (idx + 3) % 4;
            ab = gray[idx];
            if (ab == 2'b00) m_q1 = 1'b0;
            else if (ab == 2'b10) m_q2 = 1'b0;
            else if (ab == 2'b01) m_q2 = 1'b1;
            else if (!m_q1) begin
                m_q1 = 1'b1;
                if (m_q2) begin m_l++; m_pos = m_pos - 8'd1; end
                else begin m_r++; m_pos = m_pos + 8'd1; end
            end
            ROTA = ab[1];
            ROTB = ab[0];
            repeat ($urandom_range(1, 3)) begin
                tick();
                if (rot_right) cnt_r++;
                if (rot_left) cnt_l++;
                if (rot_right && rot_left) both++;
            end
        end
        repeat (6) begin
            tick();
            if (rot_right) cnt_r++;
            if (rot_left) cnt_l++;
        end
        n_checks++;
        if (rot_pos !== m_pos) $display("FAIL rot_rand_pos: got %0d required %0d", rot_pos, m_pos);
        else n_pass++;
        n_checks++;
        if (cnt_r != m_r || cnt_l != m_l)
            $display("FAIL rot_rand_pulses: got r=%0d l=%0d required r=%0d l=%0d", cnt_r, cnt_l, m_r, m_l);
        else n_pass++;
        n_checks++;
        if (both != 0) $display("FAIL rot_rand_both: got %0d cycles required 0", both);
        else n_pass++;
    endtask
`else
    task automatic test_rot_disabled();
        int bad;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            {ROTA, ROTB} = 2'($urandom);
            tick();
            if ({rot_right, rot_left, rot_pos} !== 10'd0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL rot_disabled: got %0d nonzero cycles required 0", bad);
        else n_pass++;
        zero_inputs();
    endtask
`endif

    initial begin
        zero_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        test_reset();
        test_sw();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random_buttons();
`ifdef ROTARY_DECODE_EN
        test_rot_direction();
        test_rot_wrap();
        test_rot_random();
`else
        test_rot_disabled();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
